// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Arbitrates three writeback requesters (0 = ALU, 1 = LSU, 2 = MUL/DIV)
//   onto the single GPR write port. After reset it first clears x1..x31
//   with zeros, one register per clock. It then grants requesters
//   round-robin, one transfer per cycle, with a one-cycle write latency.
//
// Ports
//   i_clk       rising-edge clock
//   i_resetn    asynchronous active-low reset
//   i_wbValid   [2:0]   per-requester write request
//   i_wbAddr    [14:0]  per-requester destination index, 5 bits each
//   i_wbData    [95:0]  per-requester write data, 32 bits each
//   o_wbReady   [2:0]   per-requester accept (combinational, one-hot)
//   o_rdWe              GPR write enable (registered)
//   o_rdAddr    [4:0]   GPR write index (registered)
//   o_rdData    [31:0]  GPR write data (registered)
//   o_initDone          high once the post-reset clear has finished

// Per-requester slice: gates the requester's addr/data by its grant so the
// top level can combine all requesters with a plain OR.
module gpr_wb_lane (
    input  logic        valid,
    input  logic        grant,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    output logic        xfer,
    output logic [4:0]  addr_m,
    output logic [31:0] data_m
);
    assign xfer   = valid & grant;
    assign addr_m = {5{xfer}} & addr;
    assign data_m = {32{xfer}} & data;
endmodule

module gpr_wb_arbiter (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic [2:0]  i_wbValid,
    input  logic [14:0] i_wbAddr,
    input  logic [95:0] i_wbData,
    output logic [2:0]  o_wbReady,
    output logic        o_rdWe,
    output logic [4:0]  o_rdAddr,
    output logic [31:0] o_rdData,
    output logic        o_initDone
);
    localparam int NUM_REQ = 3;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                    state_q, state_d;
    logic [4:0]                clr_cnt_q, clr_cnt_d;
    logic [1:0]                ptr_q, ptr_d;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        xfer;
    logic [NUM_REQ-1:0][4:0]   addr_m;
    logic [NUM_REQ-1:0][31:0]  data_m;
    logic [4:0]                sel_addr;
    logic [31:0]               sel_data;
    logic                      we_d;
    logic [4:0]                addr_d;
    logic [31:0]               data_d;
    logic                      done_d;
    logic                      found;
    logic [2:0]                scan;

    // Round-robin grant: the first valid requester scanning ptr, ptr+1 and
    // ptr+2 (mod 3). The grant depends only on state, ptr and valid.
    always_comb begin
        grant = '0;
        found = 1'b0;
        scan  = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan = {1'b0, ptr_q} + 3'(i);
                if (scan >= 3'd3)
                    scan = scan - 3'd3;
                if (!found && i_wbValid[scan[1:0]]) begin
                    grant[scan[1:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
    end

    assign o_wbReady = grant;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        gpr_wb_lane u_lane (
            .valid  (i_wbValid[g]),
            .grant  (grant[g]),
            .addr   (i_wbAddr[5*g +: 5]),
            .data   (i_wbData[32*g +: 32]),
            .xfer   (xfer[g]),
            .addr_m (addr_m[g]),
            .data_m (data_m[g])
        );
    end

    // At most one lane is non-zero, so an OR works as the mux.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr = sel_addr | addr_m[i];
            sel_data = sel_data | data_m[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        we_d      = 1'b0;
        addr_d    = o_rdAddr;
        data_d    = o_rdData;
        done_d    = o_initDone;
        case (state_q)
            CLEAR: begin
                we_d      = 1'b1;
                addr_d    = clr_cnt_q;
                data_d    = '0;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                if (|xfer) begin
                    // x0 is hardwired: accept the request but suppress the write.
                    we_d   = (sel_addr != 5'd0);
                    addr_d = sel_addr;
                    data_d = sel_data;
                    // Priority moves to the requester after the winner.
                    ptr_d  = xfer[0] ? 2'd1 : (xfer[1] ? 2'd2 : 2'd0);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= 5'd1;
            ptr_q      <= 2'd0;
            o_rdWe     <= 1'b0;
            o_rdAddr   <= '0;
            o_rdData   <= '0;
            o_initDone <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ptr_q      <= ptr_d;
            o_rdWe     <= we_d;
            o_rdAddr   <= addr_d;
            o_rdData   <= data_d;
            o_initDone <= done_d;
        end
    end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: a behavioural model tracks the
// expected write port and grant. A negedge process compares the DUT with
// the model every cycle. Directed scenarios pin the model with literals.
// A randomized phase then exercises arbitration with held requests.
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [2:0]  vld;
    logic [4:0]  addr [3];
    logic [31:0] data [3];
    logic [14:0] wb_addr;
    logic [95:0] wb_data;
    logic [2:0]  o_wbReady;
    logic        o_rdWe;
    logic [4:0]  o_rdAddr;
    logic [31:0] o_rdData;
    logic        o_initDone;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit        m_run  = 0;
    int        m_cnt  = 1;
    int        m_p    = 0;
    bit        m_we   = 0;
    int        m_addr = 0;
    int        m_data = 0;
    bit        m_done = 0;
    bit [2:0]  m_acc  = 0;

    always #5 clk = ~clk;

    always_comb begin
        wb_addr = '0;
        wb_data = '0;
        for (int k = 0; k < 3; k++) begin
            wb_addr[5*k +: 5]   = addr[k];
            wb_data[32*k +: 32] = data[k];
        end
    end

    gpr_wb_arbiter dut (
        .i_clk      (clk),
        .i_resetn   (rstn),
        .i_wbValid  (vld),
        .i_wbAddr   (wb_addr),
        .i_wbData   (wb_data),
        .o_wbReady  (o_wbReady),
        .o_rdWe     (o_rdWe),
        .o_rdAddr   (o_rdAddr),
        .o_rdData   (o_rdData),
        .o_initDone (o_initDone)
    );

    function automatic int pick(input logic [2:0] v, input int p);
        for (int i = 0; i < 3; i++)
            if (v[(p + i) % 3]) return (p + i) % 3;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: clear x1..x31, then round-robin with 1-cycle write latency.
    always @(posedge clk or negedge rstn) begin : model
        int g;
        if (!rstn) begin
            m_run = 0; m_cnt = 1; m_p = 0; m_we = 0;
            m_addr = 0; m_data = 0; m_done = 0; m_acc = 0;
        end else if (!m_run) begin
            m_we = 1; m_addr = m_cnt; m_data = 0; m_acc = 0;
            if (m_cnt == 31) begin m_run = 1; m_done = 1; end
            m_cnt = m_cnt + 1;
        end else begin
            g = pick(vld, m_p);
            m_acc = 0;
            m_we  = 0;
            if (g >= 0) begin
                m_acc[g] = 1;
                m_p      = (g + 1) % 3;
                m_we     = (addr[g] != 0);
                m_addr   = addr[g];
                m_data   = data[g];
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin : cmp
        int g;
        logic [2:0] er;
        g  = pick(vld, m_p);
        er = (m_run && g >= 0) ? 3'(1 << g) : 3'b000;
        chk("ready", 32'(o_wbReady), 32'(er));
        chk("we", 32'(o_rdWe), 32'(m_we));
        chk("init_done", 32'(o_initDone), 32'(m_done));
        if (m_we) begin
            chk("addr", 32'(o_rdAddr), 32'(m_addr));
            chk("data", o_rdData, 32'(m_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
        vld[k]  = v;
        addr[k] = a;
        data[k] = d;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        vld = 3'b000;
        for (int k = 0; k < 3; k++) begin addr[k] = 5'd0; data[k] = 32'd0; end
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vld = 3'b111;
        addr[0] = 5'd3; addr[1] = 5'd4; addr[2] = 5'd6;
        #1;
        chk("rst_we", 32'(o_rdWe), 32'd0);
        chk("rst_addr", 32'(o_rdAddr), 32'd0);
        chk("rst_data", o_rdData, 32'd0);
        chk("rst_done", 32'(o_initDone), 32'd0);
        chk("rst_ready", 32'(o_wbReady), 32'd0);
        rstn = 1'b1;

        // Clear sequence with all valids high
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("clr_we", 32'(o_rdWe), 32'd1);
            chk("clr_addr", 32'(o_rdAddr), 32'(i));
            chk("clr_data", o_rdData, 32'd0);
            chk("clr_done", 32'(o_initDone), 32'(i == 31));
            if (i < 31) chk("clr_ready", 32'(o_wbReady), 32'd0);
        end
        vld = 3'b000;
        tick();
        chk("idle_we", 32'(o_rdWe), 32'd0);

        // Only requester 1
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("r1_ready", 32'(o_wbReady), 32'b010);
        tick();
        vld[1] = 1'b0;
        chk("r1_we", 32'(o_rdWe), 32'd1);
        chk("r1_addr", 32'(o_rdAddr), 32'd5);
        chk("r1_data", o_rdData, 32'hDEADBEEF);

        // P = 2: requesters 0 and 1 -> 0 first, then 1
        set_req(0, 1'b1, 5'd3, 32'h111);
        set_req(1, 1'b1, 5'd4, 32'h222);
        #1 chk("p2_ready0", 32'(o_wbReady), 32'b001);
        tick();
        vld[0] = 1'b0;
        chk("p2_addr0", 32'(o_rdAddr), 32'd3);
        chk("p2_data0", o_rdData, 32'h111);
        #1 chk("p2_ready1", 32'(o_wbReady), 32'b010);
        tick();
        vld[1] = 1'b0;
        chk("p2_addr1", 32'(o_rdAddr), 32'd4);
        chk("p2_data1", o_rdData, 32'h222);

        // Requester 2 with address 0: accepted, no write, P -> 0
        set_req(2, 1'b1, 5'd0, 32'h5555);
        #1 chk("x0_ready", 32'(o_wbReady), 32'b100);
        tick();
        vld[2] = 1'b0;
        chk("x0_we", 32'(o_rdWe), 32'd0);

        // P = 0, all three valid and held: grants 0, 1, 2 back to back
        set_req(0, 1'b1, 5'd7, 32'hA0);
        set_req(1, 1'b1, 5'd8, 32'hA1);
        set_req(2, 1'b1, 5'd9, 32'hA2);
        for (int k = 0; k < 3; k++) begin
            #1 chk("rr_ready", 32'(o_wbReady), 32'(1 << k));
            tick();
            vld[k] = 1'b0;
            chk("rr_we", 32'(o_rdWe), 32'd1);
            chk("rr_addr", 32'(o_rdAddr), 32'(7 + k));
            chk("rr_data", o_rdData, 32'hA0 + 32'(k));
        end
        vld = 3'b111;
        #1 chk("rr_wrap_ready", 32'(o_wbReady), 32'b001);
        vld = 3'b000;
        tick();
        chk("rr_idle_we", 32'(o_rdWe), 32'd0);
        chk("rr_hold_addr", 32'(o_rdAddr), 32'd9);

        // Randomized phase: requests held until accepted
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!vld[k] || m_acc[k]) begin
                    vld[k]  = ($urandom_range(0, 2) != 0);
                    addr[k] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    data[k] = $urandom;
                end
            end
            tick();
        end
        vld = 3'b000;
        tick();

        // Reset mid-clear at address 17
        rstn = 1'b0;
        #1 rstn = 1'b1;
        for (int i = 1; i <= 17; i++) tick();
        chk("mid_addr17", 32'(o_rdAddr), 32'd17);
        vld = 3'b111;
        rstn = 1'b0;
        #1;
        chk("mid_rst_we", 32'(o_rdWe), 32'd0);
        chk("mid_rst_addr", 32'(o_rdAddr), 32'd0);
        chk("mid_rst_done", 32'(o_initDone), 32'd0);
        chk("mid_rst_ready", 32'(o_wbReady), 32'd0);
        rstn = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("re_clr_addr", 32'(o_rdAddr), 32'(i));
            chk("re_clr_done", 32'(o_initDone), 32'(i == 31));
            if (i == 31) vld = 3'b000;
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
Parameters: none; the block supports exactly 3 writeback requesters (0 = ALU, 1 = LSU, 2 = MUL/DIV).
REQ-001 The block SHALL provide these ports, one per line (clock and reset first):
- i_clk  in  1  rising-edge clock
- i_resetn  in  1  reset, asynchronous, active-low
- i_wbValid  in  3  per-requester write request; bit k = requester k
- i_wbAddr  in  15  destination register index; bits [5k+4:5k] = requester k
- i_wbData  in  96  write data; bits [32k+31:32k] = requester k
- o_wbReady  out  3  per-requester accept; bit k = requester k
- o_rdWe  out  1  GPR write-port enable
- o_rdAddr  out  5  GPR write-port register index
- o_rdData  out  32  GPR write-port data
- o_initDone  out  1  high once the post-reset register clear is complete

Function
REQ-002 The block SHALL implement a two-state FSM: CLEAR, then RUN; RUN is terminal until the next reset.
REQ-003 CLEAR SHALL use a 5-bit counter starting at 1 after reset.
REQ-004 On each rising edge in CLEAR, the block SHALL register o_rdWe=1, o_rdAddr=counter, o_rdData=0 and increment the counter.
REQ-005 The edge that registers address 31 SHALL move the FSM to RUN and set o_initDone=1; the clear sequence therefore spans 31 edges, covers addresses 1..31 and never writes x0.
REQ-006 In CLEAR, o_wbReady SHALL be 3'b000 regardless of i_wbValid.
REQ-007 In RUN, arbitration SHALL be round-robin using a 2-bit priority pointer P in {0,1,2}.
REQ-008 The winner SHALL be the first asserted i_wbValid bit scanning P, P+1, P+2 (mod 3).
REQ-009 o_wbReady SHALL be combinational, one-hot on the winner, and all-zero when no valid is asserted.
REQ-010 A transfer SHALL occur when i_wbValid[k] and o_wbReady[k] are both high at a rising edge; at most one transfer is allowed per cycle.
REQ-011 On a transfer from requester k, P SHALL update to (k+1) mod 3 at the same edge; P SHALL hold when no transfer occurs.
REQ-012 Write latency SHALL be 1 cycle: a transfer at edge t drives o_rdWe/o_rdAddr/o_rdData from edge t to edge t+1, with addr/data taken from requester k.
REQ-013 A transfer whose address is 0 SHALL be accepted (ready high, P advances) but SHALL register o_rdWe=0.
REQ-014 In RUN cycles with no transfer, o_rdWe SHALL be registered 0; o_rdAddr/o_rdData SHALL hold their previous values.
REQ-015 Requesters SHALL hold valid, addr and data stable until accepted; the block SHALL NOT rely on a requester dropping valid without a transfer.
REQ-016 o_wbReady SHALL depend only on state, P and i_wbValid, never on i_wbAddr or i_wbData.

Reset
REQ-017 Assertion of i_resetn=0 SHALL asynchronously force:
- state=CLEAR, counter=1, P=0
- o_rdWe=0, o_rdAddr=0, o_rdData=0, o_initDone=0
REQ-018 Consequently, o_wbReady SHALL be 0 while reset is asserted.
REQ-019 A reset asserted mid-CLEAR or mid-RUN SHALL abort all activity; any accepted-but-unissued write is discarded.
REQ-020 After deassertion, the full 31-write clear sequence SHALL restart from address 1.
REQ-021 The first rising edge after deassertion SHALL register the address-1 clear write.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, all valids high -> o_rdWe=1 with addr 1..31, data 0 on 31 consecutive edges; o_wbReady=0 throughout; o_initDone=1 after edge 31.
- RUN, only requester 1 valid (addr 5, data 0xDEADBEEF) -> o_wbReady=3'b010 the same cycle; next cycle o_rdWe=1, o_rdAddr=5, o_rdData=0xDEADBEEF.
- RUN, P=0, all three valid and held -> grants on requester 0, 1, 2 in consecutive cycles; o_rdWe high on 3 consecutive cycles; then P=0.
- Requester 2 valid with addr 0 -> o_wbReady[2]=1, o_rdWe stays 0, P becomes 0.
- P=2 after grant to 1, requesters 0 and 1 valid -> requester 0 granted first, then 1.
- Reset asserted at clear address 17 -> outputs 0 immediately; after release, clear restarts at address 1 and o_initDone rises only after 31 further edges.
